// File: rtl/gpr_file_mp.sv
// gpr_file_mp: parametrised general-purpose register file for the ysyx core.
//
// Sits between decode (read/issue) and writeback (write). Storage is not reset.
// After reset a sequencer zeroes one register per cycle, and ready rises when it is done.
// A per-register scoreboard bit marks registers with an outstanding producer.
//
// Ports:
//   i_cpu_clk   clock; all state updates on its rising edge
//   i_cpu_rs    synchronous active-low reset
//   i_rd_addr   NRD read addresses, port i = [i*AW +: AW]
//   o_rd_data   NRD combinational read data, port i = [i*XLEN +: XLEN]
//   o_rd_busy   scoreboard pending bit per read port
//   i_wr_en     writeback write enable
//   i_wr_addr   writeback destination
//   i_wr_data   writeback data
//   i_iss_en    issue: mark i_iss_addr as pending
//   i_iss_addr  issued destination register
//   o_ready     high once the init clear has completed
module gpr_file_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic                i_cpu_clk,
    input  logic                i_cpu_rs,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [XLEN-1:0]     i_wr_data,
    input  logic                i_iss_en,
    input  logic [AW-1:0]       i_iss_addr,
    output logic                o_ready
);

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StReady = 2'd1
    } state_e;

    state_e          r_state;
    logic [AW-1:0]   r_clr_idx;
    logic            r_ready;
    logic [NREG-1:0] r_sb;
    logic [XLEN-1:0] r_regs [NREG];

    logic w_wr_ok;
    logic w_iss_ok;

    assign w_wr_ok  = (r_state == StReady) && i_wr_en  && !(ZERO_REG && (i_wr_addr  == '0));
    assign w_iss_ok = (r_state == StReady) && i_iss_en && !(ZERO_REG && (i_iss_addr == '0));

    // Control FSM and scoreboard; ready is registered alongside the state.
    always_ff @(posedge i_cpu_clk) begin
        if (!i_cpu_rs) begin
            r_state   <= StClear;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
            r_sb      <= '0;
        end else begin
            unique case (r_state)
                StClear: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == AW'(NREG - 1)) begin
                        r_state <= StReady;
                        r_ready <= 1'b1;
                    end
                end
                StReady: begin
                    if (w_wr_ok) begin
                        r_sb[i_wr_addr] <= 1'b0;
                    end
                    // Issue is applied after the write so a same-address set wins.
                    if (w_iss_ok) begin
                        r_sb[i_iss_addr] <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StClear;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the clear sequence zeroes it instead.
    always_ff @(posedge i_cpu_clk) begin
        if (i_cpu_rs) begin
            if (r_state == StClear) begin
                r_regs[r_clr_idx] <= '0;
            end else if (w_wr_ok) begin
                r_regs[i_wr_addr] <= i_wr_data;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_ra = i_rd_addr[g*AW +: AW];

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (r_ready) begin
                if (ZERO_REG && (w_ra == '0)) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end else if (BYPASS && i_wr_en && (i_wr_addr == w_ra)) begin
                    // Forwarded value is the one being written, so it is never pending.
                    w_data = i_wr_data;
                    w_busy = 1'b0;
                end else begin
                    w_data = r_regs[w_ra];
                    w_busy = r_sb[w_ra];
                end
            end
        end

        assign o_rd_data[g*XLEN +: XLEN] = w_data;
        assign o_rd_busy[g]              = w_busy;
    end

    assign o_ready = r_ready;

endmodule
